alu_share_arbiter: RTL

Round-robin arbiter that time-shares the single 32-bit pipeline ALU between two requesters: port 0, the EX stage, and port 1, the branch-compare/address unit. It takes one operation per cycle on a request/grant handshake and drives the shared ALU inputs. It captures the ALU result and flags into a one-entry output register, which is released on a valid/ready handshake tagged with the requester id. It sits between the pipeline control logic and the ALU instance.

---
 rtl/alu_share_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the EX stage (port 0)
// and the branch/address unit (port 1), with a one-entry tagged result register.
`timescale 1ns/1ps

module alu_share_arbiter #(
    parameter int DATA_W  = 32,
    parameter bit RR_INIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [2:0]        op0,
    input  logic [2:0]        op1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_oper,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_ovf,
    output logic              res_valid,
    output logic              res_id,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              res_carry,
    output logic              res_ovf,
    input  logic              res_ready
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state;
    logic              last_gnt;
    logic [DATA_W-1:0] hold_a;
    logic [DATA_W-1:0] hold_b;
    logic [2:0]        hold_oper;
    logic              can_issue;
    logic              grant_any;

    assign res_valid = (state == FULL);
    assign grant_any = gnt0 | gnt1;

    // Idle cycles replay the last granted operands so the ALU inputs do not toggle.
    always_comb begin
        can_issue = !res_valid || res_ready;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        if (!rst && can_issue) begin
            if (req0 && req1) begin
                gnt0 = last_gnt;
                gnt1 = !last_gnt;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
        alu_a    = hold_a;
        alu_b    = hold_b;
        alu_oper = hold_oper;
        if (gnt1) begin
            alu_a    = a1;
            alu_b    = b1;
            alu_oper = op1;
        end else if (gnt0) begin
            alu_a    = a0;
            alu_b    = b0;
            alu_oper = op0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            last_gnt  <= RR_INIT;
            res_id    <= 1'b0;
            res_data  <= '0;
            res_zero  <= 1'b0;
            res_carry <= 1'b0;
            res_ovf   <= 1'b0;
            hold_a    <= '0;
            hold_b    <= '0;
            hold_oper <= 3'b000;
        end else begin
            case (state)
                EMPTY: if (grant_any) state <= FULL;
                FULL:  if (!grant_any && res_ready) state <= EMPTY;
                default: state <= EMPTY;
            endcase
            // A grant always reloads the register; a same-cycle read just hands it over.
            if (grant_any) begin
                last_gnt  <= gnt1;
                res_id    <= gnt1;
                res_data  <= alu_result;
                res_zero  <= alu_zero;
                res_carry <= alu_carry;
                res_ovf   <= alu_ovf;
                hold_a    <= alu_a;
                hold_b    <= alu_b;
                hold_oper <= alu_oper;
            end
        end
    end

endmodule
